grf_multiport: RTL
==================

# grf_multiport

Parametrised general-purpose register file for the pipelined CPU core: configurable data width, depth and read-port count, two write ports, per-register pending scoreboard for hazard detection, and a post-reset sweep that zeroes the array one entry per cycle. Sits in the decode stage: read ports feed operand fetch, write ports take writeback from the two retiring pipes, and the issue port marks destination registers as pending.

## Interface

Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- ready  output  1  high when the init sweep is complete and the file accepts traffic
- rd_addr  input  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  output  NRD  port i addresses a pending register not resolved this cycle
- we0, we1  input  1  write enables, pipe 0 / pipe 1
- wa0, wa1  input  ADDR_W  write addresses
- wd0, wd1  input  DATA_W  write data
- iss_en  input  1  issue strobe: mark iss_addr pending
- iss_addr  input  ADDR_W  destination register being issued
- pc_tag  input  32  PC of the writing instruction, debug trace only

## Operation

- Entry 0 reads as 0, is never written, and is never pending; writes and issues to address 0 are dropped.
- Writes: on a clk edge with ready=1, weN && waN!=0 stores wdN at waN. When both write ports target the same address in one cycle, port 1 wins.
- Reads: combinational. rd_data[i] = 0 if address 0; else forwarded write data if a write to that address is active this cycle (port 1 over port 0); else stored value.
- Scoreboard: one pending bit per entry. A write clears the bit at its address; iss_en sets the bit at iss_addr. When a set and a clear target the same address in the same cycle, the set wins (the newer producer remains outstanding).
- rd_busy[i] = pending[addr] and no write to addr is active this cycle; 0 for address 0.
- Init FSM, two states:
  - INIT: entered from any state on reset. Sweep counter starts at 0; each cycle writes 0 to entry[counter] and increments. Leaves for RUN on the cycle the counter reaches 2**ADDR_W-1 (that entry is also cleared). ready=0; all writes and issues ignored; rd_data=0 and rd_busy=0 on every port.
  - RUN: normal operation, ready=1. Stays until reset.
- Reset clears every pending bit on the same edge, resets the sweep counter to 0 and enters INIT; a reset asserted mid-sweep restarts the sweep from entry 0.

## Timing

- Reset values: ready=0, all pending=0, sweep counter=0, rd_data=0, rd_busy=0.
- Sweep latency: ready rises 2**ADDR_W cycles after the last cycle reset is high (32 cycles at defaults).
- Write latency: zero cycles to read ports via forwarding; stored value visible from the next cycle.
- Scoreboard latency: issue at edge k, rd_busy high in cycle k+1; writeback in cycle m resolves rd_busy in cycle m itself (same cycle as forwarding).
- No handshake beyond ready; upstream must hold issue and writeback while ready=0.

## Configuration

- GRF_BYPASS_EN defined: same-cycle write-to-read forwarding as described; rd_busy excludes registers being written this cycle.
- GRF_BYPASS_EN undefined: reads return stored values only; a register written this cycle reads the old value, and rd_busy = pending[addr] (still high during the writeback cycle; clears on the next cycle). Scoreboard set/clear and write priority unchanged.

## Test plan

- Reset, then hold idle -> ready=0 for exactly 32 cycles, rises on cycle 33; reading all 32 entries gives 0; preloaded garbage (via hierarchical force before reset) cleared.
- RUN, we0=1 wa0=5 wd0=0x1234_5678, rd_addr port0=5 same cycle -> rd_data=0x1234_5678 (bypass on) or previous value 0 (bypass off); next cycle both give 0x1234_5678.
- we0 wa0=7 wd0=0xAAAA_AAAA and we1 wa1=7 wd1=0x5555_5555 same cycle -> entry 7 = 0x5555_5555; forwarded read same cycle = 0x5555_5555.
- iss_en addr 9 at edge k -> rd_busy for addr 9 high from k+1; we1 wa1=9 in cycle m -> rd_busy low in cycle m (bypass on) / m+1 (bypass off); simultaneous iss_en addr 9 and write to 9 -> pending stays 1.
- Write/issue to address 0 with wd=0xFFFF_FFFF -> read of 0 stays 0, rd_busy stays 0.
- Assert reset at sweep count 10 -> sweep restarts at 0; ready rises 32 cycles after reset deasserts; pending bits set before reset are all 0; writes during INIT leave targets at 0.

Source files
------------

// File: rtl/grf_multiport.sv
// Multi-read, dual-write register file with pending scoreboard and post-reset zeroing sweep.
// Optional GRF_BYPASS_EN: same-cycle write-to-read forwarding and busy resolution.
module grf_multiport #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic [31:0]           pc_tag
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic run, wr0, wr1, iss;
  logic unused_pc_parity;

  // pc_tag is carried for debug tracing only
  assign unused_pc_parity = ^pc_tag;

  assign run   = (state_q == ST_RUN);
  assign ready = run;
  assign wr0   = run && we0 && (wa0 != '0);
  assign wr1   = run && we1 && (wa1 != '0);
  assign iss   = run && iss_en && (iss_addr != '0);

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    pend_q  <= pend_d;
    mem_q   <= mem_d;
  end

  // Next state: sweep in INIT; writes, clears and issue sets in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mem_d   = mem_q;
    if (reset) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          mem_d[cnt_q] = '0;
          cnt_d        = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr0) begin
            mem_d[wa0]  = wd0;
            pend_d[wa0] = 1'b0;
          end
          if (wr1) begin
            mem_d[wa1]  = wd1;
            pend_d[wa1] = 1'b0;
          end
          // A new producer outranks a same-cycle writeback
          if (iss) begin
            pend_d[iss_addr] = 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign ra = rd_addr[g*ADDR_W +: ADDR_W];

`ifdef GRF_BYPASS_EN
    logic hit0, hit1;
    assign hit0 = wr0 && (wa0 == ra);
    assign hit1 = wr1 && (wa1 == ra);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (run && (ra != '0)) begin
        if (hit1)      data = wd1;
        else if (hit0) data = wd0;
        else           data = mem_q[ra];
        busy = pend_q[ra] && !(hit0 || hit1);
      end
    end
`else
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (run && (ra != '0)) begin
        data = mem_q[ra];
        busy = pend_q[ra];
      end
    end
`endif

    assign rd_data[g*DATA_W +: DATA_W] = data;
    assign rd_busy[g]                  = busy;
  end

endmodule
